// File: rtl/nes_bus_pkg.sv
// Shared types and constants for the NES CPU-side bus controller: region decode,
// fixed register addresses and the OAM DMA state encoding.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        RGN_RAM,
        RGN_PPU,
        RGN_IO,
        RGN_NONE,
        RGN_PRG
    } region_e;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_ALIGN,
        DMA_ALIGN2,
        DMA_RD,
        DMA_WR
    } dma_state_e;

    localparam logic [15:0] PPU_BASE     = 16'h2000;
    localparam logic [15:0] IO_BASE      = 16'h4000;
    localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
    localparam logic [15:0] PRG_BASE     = 16'h8000;
    localparam logic [2:0]  OAMDATA_IDX  = 3'd4;
    localparam logic [15:0] OAMDATA_ADDR = PPU_BASE | {13'd0, OAMDATA_IDX};

    function automatic region_e decode_region(input logic [15:0] addr);
        if (addr < PPU_BASE)
            return RGN_RAM;
        else if (addr < IO_BASE)
            return RGN_PPU;
        else if (addr < PRG_BASE)
            return RGN_IO;
        else
            return RGN_PRG;
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: waits one or two alignment cycles after a $4014 write, then
// alternates bus reads of {page,idx} with writes of that byte to PPU OAMDATA.
module oam_dma_engine
    import nes_bus_pkg::*;
(
    input  logic        clk_ph2,
    input  logic        rst,
    input  logic        trig,
    input  logic [7:0]  trig_page,
    input  logic [7:0]  rd_data,
    output logic        dma_active,
    output logic        acc_valid,
    output logic [15:0] acc_addr,
    output logic        acc_rw,
    output logic [7:0]  acc_wdata
);

    dma_state_e state_q, state_d;
    logic       parity_q, parity_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d   = state_q;
        parity_d  = ~parity_q;
        page_d    = page_q;
        idx_d     = idx_q;
        acc_valid = 1'b0;
        acc_addr  = 16'h0000;
        acc_rw    = 1'b1;
        acc_wdata = 8'h00;

        unique case (state_q)
            DMA_IDLE: begin
                if (trig) begin
                    page_d  = trig_page;
                    idx_d   = 8'h00;
                    state_d = DMA_ALIGN;
                end
            end
            DMA_ALIGN: begin
                // Parity has toggled since the trigger, so parity_q==0 here means it was odd then.
                state_d = parity_q ? DMA_RD : DMA_ALIGN2;
            end
            DMA_ALIGN2: begin
                state_d = DMA_RD;
            end
            DMA_RD: begin
                acc_valid = 1'b1;
                acc_addr  = {page_q, idx_q};
                acc_rw    = 1'b1;
                state_d   = DMA_WR;
            end
            DMA_WR: begin
                acc_valid = 1'b1;
                acc_addr  = OAMDATA_ADDR;
                acc_rw    = 1'b0;
                acc_wdata = rd_data;
                idx_d     = idx_q + 8'd1;
                state_d   = (idx_q == 8'hFF) ? DMA_IDLE : DMA_RD;
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_ph2 or posedge rst) begin
        if (rst) begin
            state_q  <= DMA_IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
        end
    end

    assign dma_active = (state_q != DMA_IDLE);

endmodule

// File: rtl/cpu_bus_ctrl.sv
// NES CPU bus controller: address decode, mirrored work RAM, PPU/PRG steering and
// registered read mux. Define OAM_DMA_EN to build in the $4014 OAM DMA engine.
module cpu_bus_ctrl
    import nes_bus_pkg::*;
#(
    parameter int RAM_AW = 11,
    parameter int PRG_AW = 15
) (
    input  logic              clk_ph2,
    input  logic              rst,
    input  logic [15:0]       Addr_bus,
    input  logic              cpu_rw,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        Data_bus,
    output logic              cpu_rdy,
    output logic              ppu_cs,
    output logic              ppu_we,
    output logic [2:0]        ppu_addr,
    output logic [7:0]        ppu_wdata,
    input  logic [7:0]        ppu_rdata,
    output logic [PRG_AW-1:0] prg_addr,
    input  logic [7:0]        prg_data,
    output logic              dma_active
);

    logic        dma_valid;
    logic [15:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  dma_wdata;

    logic        acc_valid;
    logic [15:0] acc_addr;
    logic        acc_rw;
    logic [7:0]  acc_wdata;

    region_e     rgn;
    region_e     sel_q, sel_d;
    logic        ram_we;
    logic [7:0]  ram_mem [2**RAM_AW];
    logic [7:0]  ram_rdata_q;

`ifdef OAM_DMA_EN
    logic dma_trig;

    assign dma_trig = ~rst & cpu_rdy & ~cpu_rw & (Addr_bus == OAM_DMA_ADDR);
    assign cpu_rdy  = ~dma_active;

    oam_dma_engine u_dma (
        .clk_ph2    (clk_ph2),
        .rst        (rst),
        .trig       (dma_trig),
        .trig_page  (cpu_dout),
        .rd_data    (Data_bus),
        .dma_active (dma_active),
        .acc_valid  (dma_valid),
        .acc_addr   (dma_addr),
        .acc_rw     (dma_rw),
        .acc_wdata  (dma_wdata)
    );
`else
    assign cpu_rdy    = 1'b1;
    assign dma_active = 1'b0;
    assign dma_valid  = 1'b0;
    assign dma_addr   = 16'h0000;
    assign dma_rw     = 1'b1;
    assign dma_wdata  = 8'h00;
`endif

    // The DMA engine owns the bus while active; CPU inputs are ignored then.
    always_comb begin
        if (dma_active) begin
            acc_valid = dma_valid;
            acc_addr  = dma_addr;
            acc_rw    = dma_rw;
            acc_wdata = dma_wdata;
        end else begin
            acc_valid = ~rst;
            acc_addr  = Addr_bus;
            acc_rw    = cpu_rw;
            acc_wdata = cpu_dout;
        end
    end

    always_comb begin
        rgn       = decode_region(acc_addr);
        sel_d     = RGN_NONE;
        ram_we    = 1'b0;
        ppu_cs    = 1'b0;
        ppu_we    = 1'b0;
        ppu_addr  = 3'd0;
        ppu_wdata = 8'h00;
        prg_addr  = '0;
        if (acc_valid) begin
            sel_d = rgn;
            unique case (rgn)
                RGN_RAM: ram_we = ~acc_rw;
                RGN_PPU: begin
                    ppu_cs    = 1'b1;
                    ppu_we    = ~acc_rw;
                    ppu_addr  = acc_addr[2:0];
                    ppu_wdata = acc_rw ? 8'h00 : acc_wdata;
                end
                RGN_PRG: prg_addr = acc_addr[PRG_AW-1:0];
                default: ;
            endcase
        end
    end

    // NOTE: the RAM array is not reset; it is plain storage and a reset would block RAM inference.
    always_ff @(posedge clk_ph2) begin
        if (ram_we)
            ram_mem[acc_addr[RAM_AW-1:0]] <= acc_wdata;
        ram_rdata_q <= ram_mem[acc_addr[RAM_AW-1:0]];
    end

    always_ff @(posedge clk_ph2 or posedge rst) begin
        if (rst)
            sel_q <= RGN_NONE;
        else
            sel_q <= sel_d;
    end

    always_comb begin
        Data_bus = 8'h00;
        unique case (sel_q)
            RGN_RAM: Data_bus = ram_rdata_q;
            RGN_PPU: Data_bus = ppu_rdata;
            RGN_PRG: Data_bus = prg_data;
            default: Data_bus = 8'h00;
        endcase
    end

endmodule
